// File: rtl/bus_pkg.sv
// Shared constants and state encoding for the bus ownership arbiter.
package bus_pkg;

  localparam int BUS_N        = 32;
  localparam int BUS_SW       = 5;
  localparam int BUS_MAX_HOLD = 16;
  localparam int BUS_HCNT_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin search: rotate requests so ptr sits at bit 0, take the lowest
// set bit, then rotate the found offset back to an absolute source index.
module rr_priority_encoder #(
  parameter int N  = 32,
  parameter int SW = 5
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic          found,
  output logic [SW-1:0] idx
);

  logic [SW:0]   shl_s;
  logic [N-1:0]  rot_s;
  logic [SW-1:0] off_s;
  logic [SW:0]   sum_s;

  assign shl_s = (SW+1)'(N) - {1'b0, ptr};
  assign rot_s = (req >> ptr) | (req << shl_s);

  // lowest set bit of the rotated vector; scanning downward lets the lowest win
  always_comb begin
    found = 1'b0;
    off_s = {SW{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      found = rot_s[i] ? 1'b1 : found;
      off_s = rot_s[i] ? SW'(i) : off_s;
    end
  end

  // rotate back, wrapping past the top source
  always_comb begin
    sum_s = {1'b0, off_s} + {1'b0, ptr};
    if (sum_s >= (SW+1)'(N)) begin
      idx = SW'(sum_s - (SW+1)'(N));
    end else begin
      idx = sum_s[SW-1:0];
    end
  end

endmodule

// File: rtl/bus_grant_encoder.sv
// Round-robin bus ownership arbiter driving the bus mux select; grants one
// source at a time and holds it until release, request withdrawal or timeout.
module bus_grant_encoder
  import bus_pkg::*;
#(
  parameter int N        = BUS_N,
  parameter int SW       = BUS_SW,
  parameter int MAX_HOLD = BUS_MAX_HOLD
) (
  input  logic          clock,
  input  logic          clear,
  input  logic [N-1:0]  req,
  input  logic          rel,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] s,
  output logic          busy,
  output logic          timeout
);

  bus_state_e            state_r, state_nxt_s;
  logic [SW-1:0]         ptr_r, ptr_nxt_s;
  logic [BUS_HCNT_W-1:0] hcnt_r, hcnt_nxt_s;
  logic [N-1:0]          grant_nxt_s;
  logic [SW-1:0]         s_nxt_s;
  logic                  busy_nxt_s;
  logic                  timeout_nxt_s;
  logic                  found_s;
  logic [SW-1:0]         idx_s;
  logic [N-1:0]          one_s;
  logic [SW-1:0]         ptr_after_s;

  assign one_s = {{(N-1){1'b0}}, 1'b1};
  assign ptr_after_s = (s == SW'(N - 1)) ? {SW{1'b0}} : s + {{(SW-1){1'b0}}, 1'b1};

  rr_priority_encoder #(
    .N  (N),
    .SW (SW)
  ) u_enc (
    .req   (req),
    .ptr   (ptr_r),
    .found (found_s),
    .idx   (idx_s)
  );

  // next-state and next-output computation; outputs are registered below
  always_comb begin
    state_nxt_s   = state_r;
    ptr_nxt_s     = ptr_r;
    hcnt_nxt_s    = hcnt_r;
    grant_nxt_s   = grant;
    s_nxt_s       = s;
    busy_nxt_s    = busy;
    timeout_nxt_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_nxt_s = OWN;
          grant_nxt_s = one_s << idx_s;
          s_nxt_s     = idx_s;
          busy_nxt_s  = 1'b1;
          hcnt_nxt_s  = {{(BUS_HCNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s = IDLE;
          grant_nxt_s = {N{1'b0}};
          busy_nxt_s  = 1'b0;
        end
      end
      OWN: begin
        // release and withdrawal outrank the hold limit, so timeout stays low then
        if (rel || !req[s]) begin
          state_nxt_s = IDLE;
          grant_nxt_s = {N{1'b0}};
          busy_nxt_s  = 1'b0;
          hcnt_nxt_s  = {BUS_HCNT_W{1'b0}};
          ptr_nxt_s   = ptr_after_s;
        end else if (hcnt_r == BUS_HCNT_W'(MAX_HOLD)) begin
          state_nxt_s   = IDLE;
          grant_nxt_s   = {N{1'b0}};
          busy_nxt_s    = 1'b0;
          hcnt_nxt_s    = {BUS_HCNT_W{1'b0}};
          ptr_nxt_s     = ptr_after_s;
          timeout_nxt_s = 1'b1;
        end else begin
          hcnt_nxt_s = hcnt_r + {{(BUS_HCNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nxt_s = IDLE;
        grant_nxt_s = {N{1'b0}};
        busy_nxt_s  = 1'b0;
        hcnt_nxt_s  = {BUS_HCNT_W{1'b0}};
      end
    endcase
  end

  // state, pointer, hold counter and output registers
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r <= IDLE;
      ptr_r   <= {SW{1'b0}};
      hcnt_r  <= {BUS_HCNT_W{1'b0}};
      grant   <= {N{1'b0}};
      s       <= {SW{1'b0}};
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
      grant   <= grant_nxt_s;
      s       <= s_nxt_s;
      busy    <= busy_nxt_s;
      timeout <= timeout_nxt_s;
    end
  end

endmodule

// File: tb/tb_bus_grant_encoder.sv
// Directed bench for bus_grant_encoder: reset, round-robin order, wrap,
// timeout, release/timeout collision and request withdrawal.
module tb_bus_grant_encoder;

  logic        clock;
  logic        clear;
  logic [31:0] req;
  logic        rel;
  logic [31:0] grant;
  logic [4:0]  s;
  logic        busy;
  logic        timeout;

  int checks;
  int errors;

  bus_grant_encoder u_dut (
    .clock   (clock),
    .clear   (clear),
    .req     (req),
    .rel     (rel),
    .grant   (grant),
    .s       (s),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  int owners [4] = '{1, 2, 8, 1};

  initial begin
    checks = 0;
    errors = 0;
    clear  = 1'b1;
    req    = 32'h0;
    rel    = 1'b0;
    #12;
    check_eq("rst_grant", grant, 32'h0);
    check_eq("rst_s", {27'h0, s}, 32'd0);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_timeout", {31'h0, timeout}, 32'd0);

    // asynchronous clear mid-tenure
    clear = 1'b0;
    req   = 32'h0000_0010;
    step();
    check_eq("pre_clr_grant", grant, 32'h0000_0010);
    check_eq("pre_clr_s", {27'h0, s}, 32'd4);
    #2 clear = 1'b1;
    #1;
    check_eq("clr_grant", grant, 32'h0);
    check_eq("clr_s", {27'h0, s}, 32'd0);
    check_eq("clr_busy", {31'h0, busy}, 32'd0);
    #1 clear = 1'b0;
    req = 32'h8000_0001;
    step();
    check_eq("post_clr_grant", grant, 32'h0000_0001);
    check_eq("post_clr_s", {27'h0, s}, 32'd0);
    req = 32'h0;
    step();
    check_eq("wd0_grant", grant, 32'h0);

    // round-robin with a release pulse after each grant
    req = 32'h0000_0106;
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("rr_s", {27'h0, s}, 32'(owners[i]));
      check_eq("rr_grant", grant, 32'h1 << owners[i]);
      check_eq("rr_busy", {31'h0, busy}, 32'd1);
      rel = 1'b1;
      step();
      rel = 1'b0;
      check_eq("rr_drop_grant", grant, 32'h0);
      check_eq("rr_drop_busy", {31'h0, busy}, 32'd0);
    end

    // wrap-around from source 31
    req = 32'h8000_0000;
    step();
    check_eq("wrap_s31", {27'h0, s}, 32'd31);
    req = 32'h8000_0004;
    rel = 1'b1;
    step();
    rel = 1'b0;
    check_eq("wrap_drop", grant, 32'h0);
    check_eq("wrap_s_hold", {27'h0, s}, 32'd31);
    step();
    check_eq("wrap_next_s", {27'h0, s}, 32'd2);
    rel = 1'b1;
    step();
    rel = 1'b0;

    // timeout after 16 held cycles
    req = 32'h0000_0020;
    step();
    check_eq("to_grant", grant, 32'h0000_0020);
    for (int i = 0; i < 15; i++) begin
      step();
      check_eq("to_hold", grant, 32'h0000_0020);
      check_eq("to_early", {31'h0, timeout}, 32'd0);
    end
    step();
    check_eq("to_drop", grant, 32'h0);
    check_eq("to_pulse", {31'h0, timeout}, 32'd1);
    check_eq("to_s", {27'h0, s}, 32'd5);
    step();
    check_eq("to_regrant", grant, 32'h0000_0020);
    check_eq("to_pulse_end", {31'h0, timeout}, 32'd0);

    // release on the same edge the hold limit is reached
    for (int i = 0; i < 15; i++) begin
      step();
    end
    check_eq("sim_held", grant, 32'h0000_0020);
    rel = 1'b1;
    step();
    rel = 1'b0;
    check_eq("sim_drop", grant, 32'h0);
    check_eq("sim_no_to", {31'h0, timeout}, 32'd0);

    // owner withdraws its request
    req = 32'h0000_0008;
    step();
    check_eq("wd_grant", grant, 32'h0000_0008);
    req = 32'h0;
    step();
    check_eq("wd_drop", grant, 32'h0);
    check_eq("wd_busy", {31'h0, busy}, 32'd0);
    check_eq("wd_no_to", {31'h0, timeout}, 32'd0);
    step();
    check_eq("wd_s_idle", {27'h0, s}, 32'd3);
    req = 32'h0000_0011;
    step();
    check_eq("wd_ptr4", {27'h0, s}, 32'd4);
    check_eq("wd_ptr4_grant", grant, 32'h0000_0010);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
